ysyx_24100029_scoreboard: RTL and testbench

Issue-stage scoreboard and scheduler between the decode stage and the execute stage. It holds one decoded instruction in an issue register and tracks pending register writes with per-register counters. Each instruction is released to execute only when it has no read-after-write (RAW) hazard, no write-after-write (WAW) counter overflow and no conflict on the non-pipelined mul/div unit. It also undoes scoreboard state for an instruction killed in the issue register and counts decode stall cycles.

---
 rtl/ysyx_24100029_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_ysyx_24100029_scoreboard.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_scoreboard.sv
// ----------------------------------------------------------------------------
// ysyx_24100029_scoreboard
//
// Issue-stage scoreboard between decode and execute. It holds one decoded
// instruction in an issue register. Per-register 2-bit counters track the
// register writes that are still pending. An instruction is released only when
// it has no RAW hazard, would not overflow a WAW counter, and does not collide
// with the non-pipelined mul/div unit.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   dec_valid / dec_ready        decode handshake
//   dec_rs1/rs2/rd, dec_use_*    source/dest indices and their use flags
//   dec_rd_wen, dec_muldiv       destination write enable, mul/div user
//   dec_payload                  opaque packet carried to execute
//   issue_valid / issue_ready    execute handshake
//   issue_payload/rd/rd_wen/muldiv  registered instruction fields
//   wb_valid, wb_rd              a register write retires
//   muldiv_done                  mul/div unit finished
//   inst_kill                    discard the instruction in the issue register
//   stall_cycles                 decode stall cycle counter (wraps)
// ----------------------------------------------------------------------------
module ysyx_24100029_scoreboard #(
    parameter int PAYLOAD_W = 128,
    parameter int MAX_PEND  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic [4:0]           dec_rd,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic                 dec_rd_wen,
    input  logic                 dec_muldiv,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [PAYLOAD_W-1:0] issue_payload,
    output logic [4:0]           issue_rd,
    output logic                 issue_rd_wen,
    output logic                 issue_muldiv,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 muldiv_done,
    input  logic                 inst_kill,
    output logic [31:0]          stall_cycles
);

    // Pending-write counters; entry 0 exists only to keep indexing simple and
    // is held at zero because x0 is never tracked.
    logic [1:0]           cnt_q [32];
    logic [1:0]           cnt_d [32];

    logic                 vld_q,     vld_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [4:0]           rd_q,      rd_d;
    logic                 rd_wen_q,  rd_wen_d;
    logic                 muldiv_q,  muldiv_d;
    logic                 mdbusy_q,  mdbusy_d;
    logic [31:0]          stall_q,   stall_d;

    logic raw, waw, md;
    logic accept, issue_hs;

    // Hazards look only at registered counters: a write-back in this cycle
    // unblocks a stalled reader one cycle later, never in the same cycle.
    assign raw = (dec_use_rs1 && dec_rs1 != 5'd0 && cnt_q[dec_rs1] != 2'd0) ||
                 (dec_use_rs2 && dec_rs2 != 5'd0 && cnt_q[dec_rs2] != 2'd0);
    assign waw = dec_rd_wen && dec_rd != 5'd0 && cnt_q[dec_rd] == 2'(MAX_PEND);
    // The unit is blocked both while busy and while a mul/div waits in issue.
    assign md  = dec_muldiv && (mdbusy_q || (vld_q && muldiv_q));

    // reset gates dec_ready so nothing is offered as accepted while held.
    assign dec_ready   = !reset && !raw && !waw && !md && !inst_kill &&
                         (!vld_q || issue_ready);
    assign issue_valid = vld_q && !inst_kill;

    assign accept   = dec_valid && dec_ready;
    assign issue_hs = issue_valid && issue_ready;

    // Counter next state: +1 accept, -1 write-back, -1 kill undo, clamped.
    always_comb begin
        int net;
        for (int r = 0; r < 32; r++) begin
            // NOTE: every comb output gets a value on every path (here, the
            // unconditional default) so no latch is inferred.
            cnt_d[r] = cnt_q[r];
            net      = 0;
            if (r != 0) begin
                net = int'(cnt_q[r]);
                if (accept && dec_rd_wen && dec_rd == 5'(r))
                    net = net + 1;
                if (wb_valid && wb_rd == 5'(r))
                    net = net - 1;
                if (inst_kill && vld_q && rd_wen_q && rd_q == 5'(r))
                    net = net - 1;
                if (net < 0)
                    cnt_d[r] = 2'd0;
                else if (net > MAX_PEND)
                    cnt_d[r] = 2'(MAX_PEND);
                else
                    cnt_d[r] = 2'(net);
            end
        end
    end

    // Issue register and side state next values.
    always_comb begin
        vld_d     = vld_q;
        payload_d = payload_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        muldiv_d  = muldiv_q;
        mdbusy_d  = mdbusy_q;
        stall_d   = stall_q;

        if (accept) begin
            vld_d     = 1'b1;
            payload_d = dec_payload;
            rd_d      = dec_rd;
            rd_wen_d  = dec_rd_wen;
            muldiv_d  = dec_muldiv;
        end else if (inst_kill || issue_hs) begin
            vld_d = 1'b0;
        end

        // A new mul/div issue wins over a completion in the same cycle.
        if (issue_hs && muldiv_q)
            mdbusy_d = 1'b1;
        else if (muldiv_done)
            mdbusy_d = 1'b0;

        if (dec_valid && !dec_ready && !inst_kill)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the counter array is reset explicitly; stale pending
            // counts after reset would deadlock readers forever.
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= 2'd0;
            vld_q     <= 1'b0;
            payload_q <= '0;
            rd_q      <= 5'd0;
            rd_wen_q  <= 1'b0;
            muldiv_q  <= 1'b0;
            mdbusy_q  <= 1'b0;
            stall_q   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= cnt_d[r];
            vld_q     <= vld_d;
            payload_q <= payload_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            muldiv_q  <= muldiv_d;
            mdbusy_q  <= mdbusy_d;
            stall_q   <= stall_d;
        end
    end

    assign issue_payload = payload_q;
    assign issue_rd      = rd_q;
    assign issue_rd_wen  = rd_wen_q;
    assign issue_muldiv  = muldiv_q;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_ysyx_24100029_scoreboard.sv
// ----------------------------------------------------------------------------
// Directed bench for ysyx_24100029_scoreboard. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later, well before the next
// edge. Expected stall counts are written out by hand at each step.
// ----------------------------------------------------------------------------
module tb_ysyx_24100029_scoreboard;

    logic         clock = 1'b0;
    logic         reset;
    logic         dec_valid, dec_ready;
    logic [4:0]   dec_rs1, dec_rs2, dec_rd;
    logic         dec_use_rs1, dec_use_rs2, dec_rd_wen, dec_muldiv;
    logic [127:0] dec_payload;
    logic         issue_valid, issue_ready;
    logic [127:0] issue_payload;
    logic [4:0]   issue_rd;
    logic         issue_rd_wen, issue_muldiv;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic         muldiv_done, inst_kill;
    logic [31:0]  stall_cycles;

    int checks_n = 0;
    int errors_n = 0;

    ysyx_24100029_scoreboard #(.PAYLOAD_W(128), .MAX_PEND(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_use_rs1  (dec_use_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .dec_rd_wen   (dec_rd_wen),
        .dec_muldiv   (dec_muldiv),
        .dec_payload  (dec_payload),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_payload(issue_payload),
        .issue_rd     (issue_rd),
        .issue_rd_wen (issue_rd_wen),
        .issue_muldiv (issue_muldiv),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .muldiv_done  (muldiv_done),
        .inst_kill    (inst_kill),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Present a decode packet: valid, rs1, use_rs1, rs2, use_rs2, rd, wen, muldiv, payload.
    task automatic present(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic wen, input logic mdv,
                           input logic [127:0] pl);
        dec_valid   = v;
        dec_rs1     = rs1;
        dec_use_rs1 = u1;
        dec_rs2     = rs2;
        dec_use_rs2 = u2;
        dec_rd      = rd;
        dec_rd_wen  = wen;
        dec_muldiv  = mdv;
        dec_payload = pl;
    endtask

    initial begin
        reset       = 1'b1;
        issue_ready = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        muldiv_done = 1'b0;
        inst_kill   = 1'b0;
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 128'h1);

        // ---------------- reset state ----------------
        #3;
        check("rst_dec_ready", dec_ready, 1'b0);
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_payload", issue_payload, 128'h0);
        check("rst_stall", stall_cycles, 32'd0);
        tick;
        tick;
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'h0);
        reset = 1'b0;
        issue_ready = 1'b1;

        // ---------------- RAW stall ----------------
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 128'hA);
        settle;
        check("raw_a_ready", dec_ready, 1'b1);
        tick;
        present(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 128'hB);
        settle;
        check("lat_issue_valid", issue_valid, 1'b1);
        check("lat_payload", issue_payload, 128'hA);
        check("lat_rd", issue_rd, 5'd5);
        check("lat_rd_wen", issue_rd_wen, 1'b1);
        check("raw_stall", dec_ready, 1'b0);
        tick;                                   // A issues, B stalls (1)
        settle;
        check("raw_stall_cnt1", stall_cycles, 32'd1);
        check("raw_a_gone", issue_valid, 1'b0);
        check("raw_still", dec_ready, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        settle;
        check("raw_no_bypass", dec_ready, 1'b0);
        tick;                                   // stall (2), cnt[5] -> 0
        wb_valid = 1'b0;
        settle;
        check("raw_released", dec_ready, 1'b1);
        check("raw_stall_cnt2", stall_cycles, 32'd2);
        tick;                                   // B accepted
        present(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 128'hC);
        settle;
        check("raw_b_payload", issue_payload, 128'hB);
        check("raw_cnt5_zero", dec_ready, 1'b1);
        tick;                                   // C (writer of x9) accepted

        // ---------------- x0 and unused sources ----------------
        present(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 128'hD);
        settle;
        check("x0_src_ready", dec_ready, 1'b1);
        dec_rs2     = 5'd9;
        dec_use_rs2 = 1'b1;
        settle;
        check("rs2_used_stall", dec_ready, 1'b0);
        dec_rs2     = 5'd0;
        dec_use_rs2 = 1'b0;
        settle;
        tick;                                   // D (rd=0 writer) accepted
        present(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 128'hE);
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        settle;
        check("x0_pending_payload", issue_payload, 128'hD);
        check("unused_rs2_ready", dec_ready, 1'b1);
        tick;                                   // E accepted, cnt[9] -> 0
        wb_valid  = 1'b0;
        dec_valid = 1'b0;
        settle;
        check("e_payload", issue_payload, 128'hE);
        tick;
        settle;
        check("idle_issue_valid", issue_valid, 1'b0);

        // ---------------- WAW saturation ----------------
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 128'h70 + 128'(i));
            settle;
            check("waw_writer_ready", dec_ready, 1'b1);
            tick;
        end
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 128'h73);
        settle;
        check("waw_fourth_stall", dec_ready, 1'b0);
        tick;                                   // stall (3)
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle;
        check("waw_no_bypass", dec_ready, 1'b0);
        tick;                                   // stall (4), cnt[7] 3 -> 2
        wb_valid = 1'b0;
        settle;
        check("waw_released", dec_ready, 1'b1);
        check("waw_stall_cnt", stall_cycles, 32'd4);
        tick;                                   // W4 accepted, cnt[7] = 3
        dec_valid = 1'b0;
        settle;
        check("waw_w4_payload", issue_payload, 128'h73);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        repeat (4) tick;                        // 3 real write-backs, 1 extra
        wb_valid = 1'b0;
        present(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 128'h74);
        settle;
        check("wb_floor_zero", dec_ready, 1'b1);
        tick;                                   // cnt[7] = 1
        dec_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd7;
        tick;                                   // cnt[7] = 0
        wb_valid = 1'b0;

        // ---------------- kill undo ----------------
        issue_ready = 1'b0;
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 128'hC12);
        settle;
        check("kill_k_ready", dec_ready, 1'b1);
        tick;
        dec_valid = 1'b0;
        settle;
        check("kill_k_valid", issue_valid, 1'b1);
        tick;
        settle;
        check("kill_k_held", issue_payload, 128'hC12);
        inst_kill = 1'b1;
        present(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 1'b0, 128'hD12);
        settle;
        check("kill_iv_comb", issue_valid, 1'b0);
        check("kill_ready_comb", dec_ready, 1'b0);
        tick;                                   // kill: not a stall cycle
        inst_kill = 1'b0;
        settle;
        check("kill_vld_clear", issue_valid, 1'b0);
        check("kill_undo_ready", dec_ready, 1'b1);
        check("kill_no_stall", stall_cycles, 32'd4);
        tick;                                   // reader of x12 accepted
        dec_valid = 1'b0;
        settle;
        check("kill_reader_payload", issue_payload, 128'hD12);
        check("kill_reader_valid", issue_valid, 1'b1);
        issue_ready = 1'b1;
        tick;

        // ---------------- mul/div structural hazard ----------------
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 128'hE1);
        settle;
        check("md_m1_ready", dec_ready, 1'b1);
        tick;
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 128'hE2);
        settle;
        check("md_issue_flag", issue_muldiv, 1'b1);
        check("md_inflight_stall", dec_ready, 1'b0);
        tick;                                   // M1 issues, mdbusy=1, stall (5)
        settle;
        check("md_busy_stall", dec_ready, 1'b0);
        dec_muldiv = 1'b0;
        settle;
        check("md_non_md_ok", dec_ready, 1'b1);
        dec_muldiv = 1'b1;
        settle;
        tick;                                   // stall (6)
        muldiv_done = 1'b1;
        settle;
        check("md_done_no_bypass", dec_ready, 1'b0);
        tick;                                   // stall (7), mdbusy -> 0
        muldiv_done = 1'b0;
        settle;
        check("md_released", dec_ready, 1'b1);
        check("md_stall_cnt", stall_cycles, 32'd7);
        tick;                                   // M2 accepted
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 128'hE3);
        muldiv_done = 1'b1;
        settle;
        check("md_m3_stall", dec_ready, 1'b0);
        tick;                                   // M2 issue + done: busy stays, stall (8)
        muldiv_done = 1'b0;
        settle;
        check("md_set_wins", dec_ready, 1'b0);
        tick;                                   // stall (9)
        muldiv_done = 1'b1;
        tick;                                   // stall (10), mdbusy -> 0
        muldiv_done = 1'b0;
        settle;
        check("md_m3_released", dec_ready, 1'b1);
        check("md_stall_cnt2", stall_cycles, 32'd10);
        tick;                                   // M3 accepted
        dec_valid = 1'b0;
        tick;                                   // M3 issues

        // ---------------- backpressure and reset ----------------
        issue_ready = 1'b0;
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 128'hB1);
        settle;
        check("bp_b1_ready", dec_ready, 1'b1);
        tick;
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 128'hB2);
        for (int i = 0; i < 5; i++) begin
            settle;
            check("bp_payload_stable", issue_payload, 128'hB1);
            check("bp_rd_stable", issue_rd, 5'd20);
            check("bp_dec_ready", dec_ready, 1'b0);
            tick;                               // stall (11..15)
        end
        settle;
        check("bp_stall_cnt", stall_cycles, 32'd15);
        reset = 1'b1;                           // mid-cycle, asynchronous
        settle;
        check("arst_issue_valid", issue_valid, 1'b0);
        check("arst_payload", issue_payload, 128'h0);
        check("arst_rd", issue_rd, 5'd0);
        check("arst_rd_wen", issue_rd_wen, 1'b0);
        check("arst_muldiv", issue_muldiv, 1'b0);
        check("arst_stall", stall_cycles, 32'd0);
        check("arst_dec_ready", dec_ready, 1'b0);
        tick;
        reset    = 1'b0;
        wb_valid = 1'b1;                        // late write-back of x20
        wb_rd    = 5'd20;
        issue_ready = 1'b1;
        present(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd22, 1'b0, 1'b0, 128'hB3);
        settle;
        check("post_rst_ready", dec_ready, 1'b1);
        tick;
        wb_valid  = 1'b0;
        dec_valid = 1'b0;
        settle;
        check("post_rst_payload", issue_payload, 128'hB3);
        check("post_rst_stall", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
